move_entry_ctrl: RTL
====================

// Module: move_entry_ctrl
// PURPOSE
//  Producer side of the board-cursor step interface. Turns five raw pushbuttons into a chess move.
//  Per button: synchronise, debounce, edge-detect. The resulting one-cycle step events wrap an
//  8x8 cursor (file/rank 0..7), the same wrap-around stepping the display counters consume.
//  Two SELECT presses (source, then destination) form a move. The move is offered to the game
//  logic on a valid/ready handshake.
// PARAMETERS
//  DB_CYCLES  500000  consecutive identical synced samples needed to accept a new button level
//                     (10 ms @ 50 MHz); must be >= 1
//  DB_W       20      debounce counter width; must hold DB_CYCLES
// PORTS
//  clk           in   1  system clock; all logic is on the rising edge
//  reset         in   1  synchronous, active-high reset
//  btn_up        in   1  raw async button, active-high: rank+1
//  btn_down      in   1  raw async button: rank-1
//  btn_right     in   1  raw async button: file+1
//  btn_left      in   1  raw async button: file-1
//  btn_sel       in   1  raw async button: select square
//  move_ready    in   1  consumer accepts move this cycle
//  file          out  3  cursor file, 0..7
//  rank          out  3  cursor rank, 0..7
//  picking_to    out  1  1 = source latched, waiting for destination
//  from_sq       out  6  {rank,file} of source square
//  to_sq         out  6  {rank,file} of destination square
//  move_valid    out  1  move offered; from_sq/to_sq stable while high
// BEHAVIOUR
//  Reset (sync): sync flops, debounced levels, counters = 0; file=rank=0; from_sq=to_sq=0;
//   move_valid=0; picking_to=0; FSM=PICK_FROM. Reset wins over every other event in that cycle.
//  Input path, per button:
//   - 2-flop synchroniser.
//   - Debounce counter clears whenever the synced sample equals the debounced level.
//   - Otherwise it increments. On reaching DB_CYCLES the debounced level flips and the counter
//     clears.
//   - A press event is a one-cycle pulse on a 0->1 debounced transition; releases produce none.
//   - A button held through reset release yields one press, DB_CYCLES+2 cycles after release.
//  Latency: raw input stable high from edge t -> press pulse high in cycle t+DB_CYCLES+2 ->
//   cursor/FSM registers update at the following edge.
//  Cursor (only in PICK_FROM / PICK_TO; presses ignored in OFFER):
//   - right: file 7->0, else +1. left: file 0->7, else -1. up/down do the same on rank.
//   - up+down in the same cycle: rank unchanged. left+right in the same cycle: file unchanged.
//   - Events on different axes in the same cycle both apply.
//   - A step and a select in the same cycle: select uses the pre-step {rank,file}; the step
//     still applies.
//  FSM:
//   - PICK_FROM: sel -> from_sq<={rank,file}; go to PICK_TO (picking_to=1).
//   - PICK_TO, sel on a square != from_sq: to_sq<={rank,file}; go to OFFER; move_valid=1 from
//     the next cycle.
//   - PICK_TO, sel on the same square: cancel. Go to PICK_FROM; from_sq unchanged;
//     picking_to=0.
//   - OFFER: hold move_valid, from_sq, to_sq, and the cursor. On move_valid & move_ready at
//     an edge: move_valid=0, go to PICK_FROM; cursor keeps its position.
//   - move_ready while not in OFFER is ignored.
//  Width rules: file and rank are exactly 3 bits; wrap is explicit, never relies on overflow
//   side effects. from_sq and to_sq are {rank[2:0],file[2:0]}.
// TESTING (bench uses DB_CYCLES=4)
//  1. Reset, btn_right high for 10 cycles -> exactly one press pulse, 6 cycles after assertion;
//     file 0->1; rank=0.
//  2. 8 separate btn_left presses from file=0 -> file sequence 7,6,5,4,3,2,1,0. 8 btn_up
//     presses from rank=0 -> 1..7,0.
//  3. Glitch: btn_up high for 3 cycles, then low -> no press, rank unchanged. Bounce 1-0-1
//     then stable high -> exactly one press.
//  4. Move: sel at (0,1) [rank,file]; right x2; sel -> move_valid=1, from_sq=6'o01,
//     to_sq=6'o03. Hold move_ready=0 for 5 cycles while pressing up: outputs and cursor
//     unchanged. move_ready=1 -> move_valid=0, PICK_FROM, cursor at (0,3).
//  5. Cancel: sel at (2,2), then sel again at (2,2) -> picking_to=0, move_valid stays 0,
//     from_sq=6'o22.
//  6. Simultaneous and reset: up+down+right in one cycle -> rank unchanged, file+1. Assert
//     reset while move_valid=1 -> next cycle all outputs at reset values.

Source files
------------

// File: rtl/move_entry_ctrl.sv
// Five raw pushbuttons -> synchronised, debounced step/select events -> 8x8 cursor and a
// two-click chess move offered on a valid/ready handshake.
module move_entry_ctrl #(
  parameter int unsigned DB_CYCLES = 500000,
  parameter int unsigned DB_W      = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_right,
  input  logic       btn_left,
  input  logic       btn_sel,
  input  logic       move_ready,
  output logic [2:0] file,
  output logic [2:0] rank,
  output logic       picking_to,
  output logic [5:0] from_sq,
  output logic [5:0] to_sq,
  output logic       move_valid
);

  localparam int unsigned NUM_BTN = 5;
  localparam int unsigned B_UP    = 0;
  localparam int unsigned B_DOWN  = 1;
  localparam int unsigned B_RIGHT = 2;
  localparam int unsigned B_LEFT  = 3;
  localparam int unsigned B_SEL   = 4;

  localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DB_CYCLES - 1);

  localparam logic [1:0] PICK_FROM = 2'd0;
  localparam logic [1:0] PICK_TO   = 2'd1;
  localparam logic [1:0] OFFER     = 2'd2;

  logic [NUM_BTN-1:0] btn_raw;
  logic [NUM_BTN-1:0] sync1;
  logic [NUM_BTN-1:0] sync2;
  logic [NUM_BTN-1:0] level;
  logic [NUM_BTN-1:0] level_d;
  logic [NUM_BTN-1:0] press;
  logic [DB_W-1:0]    cnt [NUM_BTN];

  logic [1:0] state;
  logic [1:0] state_n;
  logic [2:0] file_n;
  logic [2:0] rank_n;
  logic [5:0] from_n;
  logic [5:0] to_n;
  logic [5:0] cur_sq;
  logic       step_r;
  logic       step_l;
  logic       step_u;
  logic       step_d;
  logic       sel;

  assign btn_raw = {btn_sel, btn_left, btn_right, btn_down, btn_up};

  // Synchronise, debounce and rising-edge detect every button; press is a registered pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1   <= '0;
      sync2   <= '0;
      level   <= '0;
      level_d <= '0;
      press   <= '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1   <= btn_raw;
      sync2   <= sync1;
      level_d <= level;
      press   <= level & ~level_d;
      for (int i = 0; i < NUM_BTN; i++) begin
        if (sync2[i] == level[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          cnt[i]   <= '0;
          level[i] <= ~level[i];
        end else begin
          cnt[i] <= cnt[i] + DB_W'(1);
        end
      end
    end
  end

  // Opposing presses on one axis cancel; the cursor is frozen while a move is offered.
  assign step_r = press[B_RIGHT] & ~press[B_LEFT];
  assign step_l = press[B_LEFT]  & ~press[B_RIGHT];
  assign step_u = press[B_UP]    & ~press[B_DOWN];
  assign step_d = press[B_DOWN]  & ~press[B_UP];
  assign sel    = press[B_SEL];
  assign cur_sq = {rank, file};

  always_comb begin
    state_n = state;
    file_n  = file;
    rank_n  = rank;
    from_n  = from_sq;
    to_n    = to_sq;

    if (state != OFFER) begin
      if (step_r) begin
        file_n = (file == 3'd7) ? 3'd0 : file + 3'd1;
      end else if (step_l) begin
        file_n = (file == 3'd0) ? 3'd7 : file - 3'd1;
      end
      if (step_u) begin
        rank_n = (rank == 3'd7) ? 3'd0 : rank + 3'd1;
      end else if (step_d) begin
        rank_n = (rank == 3'd0) ? 3'd7 : rank - 3'd1;
      end
    end

    // Select always latches the pre-step square.
    case (state)
      PICK_FROM: begin
        if (sel) begin
          from_n  = cur_sq;
          state_n = PICK_TO;
        end
      end
      PICK_TO: begin
        if (sel) begin
          if (cur_sq != from_sq) begin
            to_n    = cur_sq;
            state_n = OFFER;
          end else begin
            state_n = PICK_FROM;
          end
        end
      end
      OFFER: begin
        if (move_ready) begin
          state_n = PICK_FROM;
        end
      end
      default: state_n = PICK_FROM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= PICK_FROM;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      file       <= 3'd0;
      rank       <= 3'd0;
      from_sq    <= 6'd0;
      to_sq      <= 6'd0;
      picking_to <= 1'b0;
      move_valid <= 1'b0;
    end else begin
      file       <= file_n;
      rank       <= rank_n;
      from_sq    <= from_n;
      to_sq      <= to_n;
      picking_to <= (state_n == PICK_TO);
      move_valid <= (state_n == OFFER);
    end
  end

endmodule
